// File: rtl/neuron_mac_seq.sv
// Sequential single neuron: y = act(sum(x[i]*W[i]) + BIAS), one shared multiplier,
// runtime-writable weights/bias, valid/ready on both sides, saturating ReLU/linear output.
module neuron_mac_seq #(
    parameter int INT_BITS  = 6,
    parameter int FRAC_BITS = 12,
    parameter int N_INPUTS  = 2,
    parameter int RELU      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_we,
    input  logic [$clog2(N_INPUTS+1)-1:0]         cfg_addr,
    input  logic [INT_BITS+FRAC_BITS-1:0]         cfg_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0]         in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INT_BITS+FRAC_BITS-1:0]         y
);
    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int AW = $clog2(N_INPUTS + 1);
    localparam int A  = 2*W - FRAC_BITS + AW;

    localparam logic [AW-1:0]      LAST_IDX  = AW'(N_INPUTS - 1);
    localparam logic [AW-1:0]      BIAS_ADDR = AW'(N_INPUTS);
    localparam logic signed [A-1:0] YMAX = {{(A-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [A-1:0] YMIN = {{(A-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t                         state, nxt;
    logic                           live;
    logic [AW-1:0]                  idx;
    logic signed [A-1:0]            acc;
    logic [N_INPUTS-1:0][W-1:0]     wt;
    logic signed [W-1:0]            bias;
    logic signed [W-1:0]            w_sel;
    logic signed [2*W-1:0]          prod;
    logic signed [A-1:0]            p_ext, base, r;
    logic [W-1:0]                   y_nxt;
    logic                           beat, last;

    // Weight registers: one per operand, bias at the address just past them.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_wt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                wt[i] <= '0;
            else if (cfg_we && cfg_addr == AW'(i))
                wt[i] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bias <= '0;
        else if (cfg_we && cfg_addr == BIAS_ADDR)
            bias <= $signed(cfg_data);
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_INPUTS; i++)
            if (idx == AW'(i))
                w_sel = $signed(wt[i]);
    end

    // Full-width product, arithmetic shift floors toward -inf.
    assign prod  = $signed(in_data) * w_sel;
    assign p_ext = A'(prod >>> FRAC_BITS);
    assign base  = (idx == '0) ? A'(bias) : acc;
    assign r     = base + p_ext;

    always_comb begin
        if (r > YMAX)
            y_nxt = {1'b0, {(W-1){1'b1}}};
        else if (r < YMIN)
            y_nxt = {1'b1, {(W-1){1'b0}}};
        else
            y_nxt = r[W-1:0];
        if (RELU != 0 && r < 0)
            y_nxt = '0;
    end

    assign beat = in_valid && in_ready;
    assign last = (idx == LAST_IDX);

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ACC;
        else     state <= nxt;
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACC: begin
                in_ready = live;
                if (in_valid && live && last)
                    nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    nxt = S_ACC;
            end
            default: nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
            y   <= '0;
        end else if (beat) begin
            acc <= r;
            if (last) begin
                idx <= '0;
                y   <= y_nxt;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: ReLU and linear instances share stimulus,
// expected results are hand-computed Q6.12 values.
module tb_neuron_mac_seq;
    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [17:0]        cfg_data;
    logic               in_valid;
    logic [17:0]        in_data;
    logic               out_ready;
    logic               rdy_r, rdy_l, ov_r, ov_l;
    logic signed [17:0] y_r, y_l;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.INT_BITS(6), .FRAC_BITS(12), .N_INPUTS(2), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(rdy_r), .in_data(in_data),
        .out_valid(ov_r), .out_ready(out_ready), .y(y_r));

    neuron_mac_seq #(.INT_BITS(6), .FRAC_BITS(12), .N_INPUTS(2), .RELU(0)) u_lin (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .out_valid(ov_l), .out_ready(out_ready), .y(y_l));

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input int d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = 18'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!(rdy_r && rdy_l) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("rdy_timeout", 0, 1);
    endtask

    // Checks the held result, then completes the output handshake.
    task automatic take(input string tag, input int er, input int el);
        chk({tag, "_ov_r"}, int'(ov_r), 1);
        chk({tag, "_ov_l"}, int'(ov_l), 1);
        chk({tag, "_rdy"}, int'(rdy_r | rdy_l), 0);
        chk({tag, "_y_relu"}, int'(y_r), er);
        chk({tag, "_y_lin"}, int'(y_l), el);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_clr"}, int'(ov_r | ov_l), 0);
    endtask

    task automatic sample(input string tag, input int x0, input int x1, input int er, input int el);
        wait_rdy();
        in_valid = 1'b1; in_data = 18'(x0);
        tick();
        in_data = 18'(x1);
        tick();
        in_valid = 1'b0;
        take(tag, er, el);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_rdy", int'(rdy_r | rdy_l), 0);
        chk("rst_ov", int'(ov_r | ov_l), 0);
        chk("rst_y", int'(y_l), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", int'(rdy_r & rdy_l), 1);

        // Base: (-1.0)(W0) + (-1.0)(W1) + BIAS = 4474 + 3804 - 3787
        wr(0, -4474); wr(1, -3804); wr(2, -3787);
        sample("base", -4096, -4096, 4491, 4491);
        sample("clamp", 4096, 4096, 0, -12065);

        // Gap mid-sample holds idx/acc
        wait_rdy();
        in_valid = 1'b1; in_data = -18'sd4096;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("gap_ov", int'(ov_r | ov_l), 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        take("gap", 4491, 4491);

        // Positive saturation: 2 * floor(131071^2 / 4096) >> max
        wr(0, 131071); wr(1, 131071); wr(2, 0);
        sample("sat_pos", 131071, 131071, 131071, 131071);
        // Negative saturation: -131072*131071 >>> 12 = -4194272
        wr(0, -131072); wr(1, 0);
        sample("sat_neg", 131071, 131071, 0, -131072);
        // Out-of-range address is ignored; -1 >>> 12 floors to -1
        wr(3, 999);
        wr(0, -1);
        sample("floor", 1, 0, 0, -1);

        // Backpressure: new sample presented while result is pending
        wr(0, -4474); wr(1, -3804); wr(2, -3787);
        wait_rdy();
        in_valid = 1'b1; in_data = -18'sd4096;
        tick(); tick();
        in_data = 18'sd4096;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rdy", int'(rdy_r | rdy_l), 0);
            chk("bp_y", int'(y_l), 4491);
            tick();
        end
        chk("bp_ov", int'(ov_l), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_ov_clr", int'(ov_r | ov_l), 0);
        chk("bp_rdy_back", int'(rdy_r & rdy_l), 1);
        tick(); tick();
        in_valid = 1'b0;
        take("bp_next", 0, -12065);

        // Reset mid-sample: partial sum and weights discarded
        wait_rdy();
        in_valid = 1'b1; in_data = -18'sd4096;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", int'(rdy_r | rdy_l), 0);
        tick();
        rst = 1'b0;
        tick();
        wr(2, 100);
        sample("rst_zero_w", 4096, 4096, 100, 100);
        wr(0, 4096); wr(1, 4096); wr(2, 0);
        sample("fresh", 4096, 8192, 12288, 12288);

        // W1 written on the same edge as beat 1: old value used this sample
        wait_rdy();
        in_valid = 1'b1; in_data = 18'sd4096;
        tick();
        in_data = 18'sd8192;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = '0;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        take("race_old", 12288, 12288);
        sample("race_new", 4096, 8192, 4096, 4096);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
